// File: rtl/dffram_2p_model_if.sv
// Bus bundle for dffram_2p_model.
// The master side (the bench or the SoC glue) drives the request signals.
// The slave side (the RAM model) drives BUSY and the two read-data buses.
//   CLR  : one-cycle clear request
//   BUSY : clear sequence running; port requests are ignored while high
//   EN0, WE0, A0, Di0, Do0 : port 0, read/write with byte enables
//   EN1, A1, Do1           : port 1, read-only
interface dffram_2p_model_if #(
  parameter int WORDS = 512,
  parameter int WSIZE = 4
);
  localparam int AW = $clog2(WORDS);
  localparam int DW = 8 * WSIZE;

  logic             CLR;
  logic             BUSY;
  logic             EN0;
  logic [WSIZE-1:0] WE0;
  logic [AW-1:0]    A0;
  logic [DW-1:0]    Di0;
  logic [DW-1:0]    Do0;
  logic             EN1;
  logic [AW-1:0]    A1;
  logic [DW-1:0]    Do1;

  modport master (
    output CLR, EN0, WE0, A0, Di0, EN1, A1,
    input  BUSY, Do0, Do1
  );

  modport slave (
    input  CLR, EN0, WE0, A0, Di0, EN1, A1,
    output BUSY, Do0, Do1
  );
endinterface

// File: rtl/dffram_2p_model.sv
// Behavioural two-port SRAM model used in place of hardened RAM macros.
// Port 0 reads and writes with byte enables; port 1 only reads.
// When both ports hit the same word on one edge, port 1 sees the newly written data.
// A clear engine zeroes the array one word per cycle, either after reset or on a CLR request.
// Ports:
//   CLK  : clock; all state changes on the rising edge
//   RST  : asynchronous, active-high reset
//   bus  : dffram_2p_model_if.slave, carrying the clear control and both RAM ports
// Parameters:
//   WORDS, WSIZE, RD_LAT (1 or 2), CLR_ON_RST
module dffram_2p_model #(
  parameter int WORDS      = 512,
  parameter int WSIZE      = 4,
  parameter int RD_LAT     = 1,
  parameter int CLR_ON_RST = 1
) (
  input logic               CLK,
  input logic               RST,
  dffram_2p_model_if.slave  bus
);
  localparam int AW = $clog2(WORDS);
  localparam int DW = 8 * WSIZE;

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam state_t RST_STATE = (CLR_ON_RST != 0) ? CLEAR : IDLE;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          busy;

  logic [DW-1:0] mem [WORDS];

  logic          wr_en;
  logic          collide;
  logic [DW-1:0] wr_word;

  logic signed [DW-1:0] unused_sign_probe;

  logic [DW-1:0] do0_p1, do1_p1;

  function automatic logic [DW-1:0] byte_merge(
    input logic [DW-1:0]    old_w,
    input logic [DW-1:0]    new_w,
    input logic [WSIZE-1:0] be
  );
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < WSIZE; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  assign busy     = (state_q == CLEAR);
  assign bus.BUSY = busy;

  // The bus carries raw words; the signed view only documents that no arithmetic is done here.
  assign unused_sign_probe = '0;

  // Clear FSM: state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear FSM: next state.
  // CLR is only looked at in IDLE, so a request during a clear does not restart the count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.CLR) state_d = CLEAR;
      end
      CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(WORDS - 1)) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Byte-merged word that port 0 writes. Port 1 also returns this word on a same-address hit.
  assign wr_word = byte_merge(mem[bus.A0], bus.Di0, bus.WE0);
  assign wr_en   = !busy && bus.EN0 && (|bus.WE0);
  assign collide = bus.EN0 && bus.EN1 && (bus.A0 == bus.A1) && (|bus.WE0);

  // Array: no reset, so contents survive RST.
  // Writes are suppressed while RST is held.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (busy) begin
        mem[cnt_q] <= '0;
      end else if (wr_en) begin
        mem[bus.A0] <= wr_word;
      end
    end
  end

  // Stage 1: read registers.
  // Port 0 returns the old word.
  // Port 1 returns the word as written this edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      do0_p1 <= '0;
      do1_p1 <= '0;
    end else if (busy) begin
      do0_p1 <= '0;
      do1_p1 <= '0;
    end else begin
      do0_p1 <= bus.EN0 ? mem[bus.A0] : '0;
      do1_p1 <= bus.EN1 ? (collide ? wr_word : mem[bus.A1]) : '0;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DW-1:0] do0_p2, do1_p2;

      // Stage 2: unconditional copy of stage 1
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          do0_p2 <= '0;
          do1_p2 <= '0;
        end else begin
          do0_p2 <= do0_p1;
          do1_p2 <= do1_p1;
        end
      end

      assign bus.Do0 = do0_p2;
      assign bus.Do1 = do1_p2;
    end else begin : g_lat1
      assign bus.Do0 = do0_p1;
      assign bus.Do1 = do1_p1;
    end
  endgenerate
endmodule

// File: tb/tb_dffram_2p_model.sv
// Bench for dffram_2p_model: three instances (RD_LAT=1, RD_LAT=2, CLR_ON_RST=0) share stimulus.
// Each instance is checked every cycle against a word-level reference model.
module tb_dffram_2p_model;
  localparam int N     = 3;
  localparam int WORDS = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr, en0, en1;
  logic [3:0]  we0;
  logic [3:0]  a0, a1;
  logic [31:0] di0;

  logic        busy_v [N];
  logic [31:0] do0_v  [N];
  logic [31:0] do1_v  [N];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dffram_2p_model_if #(.WORDS(WORDS), .WSIZE(4)) ifs [N] ();

  for (genvar g = 0; g < N; g++) begin : g_dut
    assign ifs[g].CLR = clr;
    assign ifs[g].EN0 = en0;
    assign ifs[g].WE0 = we0;
    assign ifs[g].A0  = a0;
    assign ifs[g].Di0 = di0;
    assign ifs[g].EN1 = en1;
    assign ifs[g].A1  = a1;
    assign busy_v[g]  = ifs[g].BUSY;
    assign do0_v[g]   = ifs[g].Do0;
    assign do1_v[g]   = ifs[g].Do1;

    dffram_2p_model #(
      .WORDS(WORDS), .WSIZE(4),
      .RD_LAT((g == 1) ? 2 : 1),
      .CLR_ON_RST((g == 2) ? 0 : 1)
    ) dut (
      .CLK(clk),
      .RST(rst),
      .bus(ifs[g])
    );
  end

  // Reference model.
  // Words of contents plus a known flag per word, the clear progress, and the
  // stage-1 and output values seen by the user.
  int          LAT [N] = '{1, 2, 1};
  int          COR [N] = '{1, 1, 0};
  logic [31:0] mem [N][WORDS];
  bit          kn  [N][WORDS];
  bit          mbusy [N];
  int          midx  [N];
  logic [31:0] s1_0 [N], s1_1 [N], o0 [N], o1 [N];
  bit          sk0 [N], sk1 [N], ok0 [N], ok1 [N];

  function automatic logic [31:0] mrg(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (new_w & mask) | (old_w & ~mask);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mbusy[k] = (COR[k] != 0);
      midx[k]  = 0;
      s1_0[k] = 0; s1_1[k] = 0; o0[k] = 0; o1[k] = 0;
      sk0[k] = 1;  sk1[k] = 1;  ok0[k] = 1; ok1[k] = 1;
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < N; k++) begin
      logic [31:0] n0, n1;
      bit          k0, k1;
      n0 = 0; n1 = 0; k0 = 1; k1 = 1;
      if (mbusy[k]) begin
        mem[k][midx[k]] = 0;
        kn[k][midx[k]]  = 1;
        midx[k]++;
        if (midx[k] == WORDS) begin
          mbusy[k] = 0;
          midx[k]  = 0;
        end
      end else begin
        if (en0) begin
          n0 = mem[k][a0];
          k0 = kn[k][a0];
        end
        if (en1) begin
          if (en0 && a0 == a1 && we0 != 0) begin
            n1 = mrg(mem[k][a1], di0, we0);
            k1 = kn[k][a1] || (we0 == 4'hF);
          end else begin
            n1 = mem[k][a1];
            k1 = kn[k][a1];
          end
        end
        if (en0 && we0 != 0) begin
          mem[k][a0] = mrg(mem[k][a0], di0, we0);
          kn[k][a0]  = kn[k][a0] || (we0 == 4'hF);
        end
        if (clr) begin
          mbusy[k] = 1;
          midx[k]  = 0;
        end
      end
      if (LAT[k] == 2) begin
        o0[k] = s1_0[k]; ok0[k] = sk0[k];
        o1[k] = s1_1[k]; ok1[k] = sk1[k];
      end else begin
        o0[k] = n0; ok0[k] = k0;
        o1[k] = n1; ok1[k] = k1;
      end
      s1_0[k] = n0; sk0[k] = k0;
      s1_1[k] = n1; sk1[k] = k1;
    end
  endtask

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("d%0d busy", k), {31'b0, busy_v[k]}, {31'b0, mbusy[k]});
      if (ok0[k]) chk($sformatf("d%0d do0", k), do0_v[k], o0[k]);
      if (ok1[k]) chk($sformatf("d%0d do1", k), do1_v[k], o1[k]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic read_all();
    for (int i = 0; i < WORDS; i++) begin
      en1 = 1'b1;
      a1  = 4'(i);
      cycle();
    end
    en1 = 1'b0;
    cycle();
    cycle();
  endtask

  int nb;

  initial begin
    rst = 1'b0; clr = 1'b0; en0 = 1'b0; en1 = 1'b0;
    we0 = '0; a0 = '0; a1 = '0; di0 = '0;
    for (int k = 0; k < N; k++) begin
      for (int w = 0; w < WORDS; w++) begin
        mem[k][w] = 0;
        kn[k][w]  = 0;
      end
    end

    // reset state
    #2 rst = 1'b1;
    model_reset();
    #1 check_all();
    cycle();
    cycle();
    rst = 1'b0;

    // reset-triggered clear lasts WORDS cycles, then the array reads zero
    nb = busy_v[0] ? 1 : 0;
    repeat (20) begin
      cycle();
      if (busy_v[0]) nb++;
    end
    chk("t1 busy cycles", 32'(nb), 32'd16);
    read_all();

    // byte writes
    en0 = 1'b1; we0 = 4'hF; a0 = 4'd5; di0 = 32'hDEADBEEF;
    cycle();
    we0 = 4'b0010; di0 = 32'h00001200;
    cycle();
    en0 = 1'b0; we0 = '0; en1 = 1'b1; a1 = 4'd5;
    cycle();
    chk("t2 do1", do1_v[0], 32'hDEAD12EF);
    en1 = 1'b0;
    cycle();

    // collision write-through
    en0 = 1'b1; we0 = 4'hF; a0 = 4'd3; di0 = 32'h11223344;
    cycle();
    we0 = 4'b1000; di0 = 32'hAA000000; en1 = 1'b1; a1 = 4'd3;
    cycle();
    chk("t3 do1", do1_v[0], 32'hAA223344);
    chk("t3 do0", do0_v[0], 32'h11223344);
    en0 = 1'b0; we0 = '0; en1 = 1'b0;
    cycle();

    // two-cycle latency and EN=0 propagation
    en0 = 1'b1; we0 = 4'hF; a0 = 4'd7; di0 = 32'h0000CAFE;
    cycle();
    en0 = 1'b0; we0 = '0; en1 = 1'b1; a1 = 4'd7;
    cycle();
    chk("t4 lat2 edge1", do1_v[1], 32'h0);
    en1 = 1'b0;
    cycle();
    chk("t4 lat2 edge2", do1_v[1], 32'h0000CAFE);
    cycle();
    chk("t4 lat2 edge3", do1_v[1], 32'h0);

    // reset in the middle of a clear; a write during the clear is dropped
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    cycle(); cycle(); cycle();
    en0 = 1'b1; we0 = 4'hF; a0 = 4'd2; di0 = 32'hFFFFFFFF;
    cycle();
    en0 = 1'b0; we0 = '0;
    cycle();
    rst = 1'b1;
    model_reset();
    #1 check_all();
    cycle();
    rst = 1'b0;

    // no auto-clear instance: usable at once, write then read back
    nb = busy_v[0] ? 1 : 0;
    chk("t6 c busy after rst", {31'b0, busy_v[2]}, 32'h0);
    en0 = 1'b1; we0 = 4'hF; a0 = 4'd9; di0 = 32'h12345678;
    cycle();
    if (busy_v[0]) nb++;
    we0 = '0;
    cycle();
    if (busy_v[0]) nb++;
    chk("t6 c rd", do0_v[2], 32'h12345678);
    en0 = 1'b0;
    repeat (18) begin
      cycle();
      if (busy_v[0]) nb++;
    end
    chk("t5 busy cycles", 32'(nb), 32'd16);
    read_all();

    // CLR request zeroes every instance in WORDS cycles
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    nb = busy_v[2] ? 1 : 0;
    repeat (20) begin
      cycle();
      if (busy_v[2]) nb++;
    end
    chk("t6 clr busy cycles", 32'(nb), 32'd16);
    read_all();

    // random traffic
    repeat (400) begin
      clr = ($urandom_range(0, 63) == 0);
      en0 = 1'($urandom);
      we0 = 4'($urandom);
      a0  = 4'($urandom);
      di0 = $urandom;
      en1 = 1'($urandom);
      a1  = ($urandom_range(0, 3) == 0) ? a0 : 4'($urandom);
      cycle();
    end
    clr = 1'b0; en0 = 1'b0; en1 = 1'b0; we0 = '0;
    repeat (20) cycle();
    read_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
